// File: rtl/ro_puf_pkg.sv
// Ring-oscillator PUF array: shared types and constants.
// FSM encoding and pipeline depths used by the array top.
package ro_puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_e;

  localparam int DRAIN_CYCLES = 3;
  localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/ro_puf_array_ro_cell.sv
// Single gated ring oscillator: enable AND followed by an odd inverter chain.
// Every net is kept so synthesis cannot collapse the loop.
module ro_cell #(
  parameter int NUM_STAGES = 7
) (
  input  logic en_i,
  (* keep = "true", dont_touch = "true" *)
  output logic osc_o
);

  (* keep = "true", dont_touch = "true" *)
  logic [NUM_STAGES:0] n;

  assign n[0] = en_i & n[NUM_STAGES];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_inv
    assign n[i+1] = ~n[i];
  end

  assign osc_o = n[NUM_STAGES];

endmodule

// File: rtl/ro_puf_array.sv
// Ring-oscillator PUF array: races two selected rings over a clk window
// and reports which one produced more synchronized rising edges.
module ro_puf_array
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO      = 16,
  parameter int NUM_STAGES  = 7,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SIM_EXT_OSC = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(NUM_RO)-1:0] sel_a,
  input  logic [$clog2(NUM_RO)-1:0] sel_b,
  input  logic [WIN_W-1:0]          window,
  input  logic [NUM_RO-1:0]         ext_osc,
  output logic                      ready,
  output logic                      resp_valid,
  output logic                      resp,
  output logic                      resp_tie,
  output logic                      resp_err,
  output logic                      resp_sat,
  output logic [CNT_W-1:0]          cnt_a,
  output logic [CNT_W-1:0]          cnt_b
);

  localparam int SW = $clog2(NUM_RO);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e state_q, state_d;
  logic [SW-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [WIN_W-1:0] tmr_q, tmr_d;
  logic [NUM_RO-1:0] en_q, en_d, osc;
  logic [SYNC_STAGES-1:0] sy_a_q, sy_b_q;
  logic pv_a_q, pv_b_q;
  logic [CNT_W-1:0] ca_q, cb_q;
  logic r_q, r_d, t_q, t_d;
  logic e_q, e_d, s_q, s_d;
  logic edge_a, edge_b, counting;

  if (SIM_EXT_OSC != 0) begin : g_ext
    assign osc = ext_osc;
  end else begin : g_ring
    for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
      ro_cell #(
        .NUM_STAGES(NUM_STAGES)
      ) u_ro (
        .en_i (en_q[g]),
        .osc_o(osc[g])
      );
    end
  end

  assign edge_a   = sy_a_q[SYNC_STAGES-1] & ~pv_a_q;
  assign edge_b   = sy_b_q[SYNC_STAGES-1] & ~pv_b_q;
  assign counting = (state_q == S_COUNT) || (state_q == S_DRAIN);

  // Synchronize selected rings; in ARM the edge history is realigned
  // so a stale sample from the previous selection can't fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sy_a_q <= '0;
      sy_b_q <= '0;
      pv_a_q <= 1'b0;
      pv_b_q <= 1'b0;
    end else begin
      sy_a_q <= {sy_a_q[SYNC_STAGES-2:0], osc[sa_d]};
      sy_b_q <= {sy_b_q[SYNC_STAGES-2:0], osc[sb_d]};
      if (state_q == S_ARM) begin
        pv_a_q <= sy_a_q[SYNC_STAGES-2];
        pv_b_q <= sy_b_q[SYNC_STAGES-2];
      end else begin
        pv_a_q <= sy_a_q[SYNC_STAGES-1];
        pv_b_q <= sy_b_q[SYNC_STAGES-1];
      end
    end
  end

  // Saturating edge counters, cleared in ARM.
  always_ff @(posedge clk) begin
    if (rst) begin
      ca_q <= '0;
      cb_q <= '0;
    end else if (state_q == S_ARM) begin
      ca_q <= '0;
      cb_q <= '0;
    end else if (counting) begin
      if (edge_a && ca_q != CMAX) ca_q <= ca_q + 1'b1;
      if (edge_b && cb_q != CMAX) cb_q <= cb_q + 1'b1;
    end
  end

  // FSM and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      tmr_q   <= '0;
      en_q    <= '0;
      r_q     <= 1'b0;
      t_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      tmr_q   <= tmr_d;
      en_q    <= en_d;
      r_q     <= r_d;
      t_q     <= t_d;
      e_q     <= e_d;
      s_q     <= s_d;
    end
  end

  // Next-state, window timer, compare and ring-enable decode.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    tmr_d   = tmr_q;
    r_d     = r_q;
    t_d     = t_q;
    e_d     = e_q;
    s_d     = s_q;
    en_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d = sel_a;
          sb_d = sel_b;
          r_d  = 1'b0;
          t_d  = 1'b0;
          s_d  = 1'b0;
          if (sel_a == sel_b) begin
            e_d     = 1'b1;
            state_d = S_DONE;
          end else begin
            e_d     = 1'b0;
            tmr_d   = (window == '0) ? '0 : window - 1'b1;
            state_d = S_ARM;
          end
        end
      end
      S_ARM: state_d = S_COUNT;
      S_COUNT: begin
        if (tmr_q == '0) begin
          tmr_d   = WIN_W'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) state_d = S_CMP;
        else tmr_d = tmr_q - 1'b1;
      end
      S_CMP: begin
        r_d     = ca_q > cb_q;
        t_d     = ca_q == cb_q;
        s_d     = (ca_q == CMAX) || (cb_q == CMAX);
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ARM || state_d == S_COUNT) begin
      en_d[sa_d] = 1'b1;
      en_d[sb_d] = 1'b1;
    end
  end

  assign ready      = state_q == S_IDLE;
  assign resp_valid = state_q == S_DONE;
  assign resp       = r_q;
  assign resp_tie   = t_q;
  assign resp_err   = e_q;
  assign resp_sat   = s_q;
  assign cnt_a      = ca_q;
  assign cnt_b      = cb_q;

endmodule

// File: tb/tb_ro_puf_array.sv
// Bench for ro_puf_array with external oscillator sources.
// Directed table, reset abort sequence and randomized challenges.
module tb_ro_puf_array;

  localparam int HMAX = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start4;
  logic [3:0] sel_a, sel_b;
  logic [15:0] window, ext_osc;
  logic ready, rv, resp, tie, err, sat;
  logic [15:0] ca, cb;
  logic ready4, rv4, resp4, tie4, err4, sat4;
  logic [3:0] ca4, cb4;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tcnt = 0;
  int per[16];
  int ph[16];
  int last_a[2];
  int last_b[2];
  logic [15:0] hist[HMAX];

  ro_puf_array #(
    .NUM_RO(16), .NUM_STAGES(7), .CNT_W(16),
    .WIN_W(16), .SIM_EXT_OSC(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .ext_osc(ext_osc), .ready(ready), .resp_valid(rv),
    .resp(resp), .resp_tie(tie), .resp_err(err),
    .resp_sat(sat), .cnt_a(ca), .cnt_b(cb)
  );

  ro_puf_array #(
    .NUM_RO(16), .NUM_STAGES(7), .CNT_W(4),
    .WIN_W(16), .SIM_EXT_OSC(1)
  ) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .ext_osc(ext_osc), .ready(ready4), .resp_valid(rv4),
    .resp(resp4), .resp_tie(tie4), .resp_err(err4),
    .resp_sat(sat4), .cnt_a(ca4), .cnt_b(cb4)
  );

  always @(negedge clk) begin
    for (int i = 0; i < 16; i++)
      ext_osc[i] = (per[i] > 0) &&
                   (((tcnt + ph[i]) % per[i]) < per[i] / 2);
    tcnt++;
  end

  always @(posedge clk) begin
    if (cyc < HMAX) hist[cyc] = ext_osc;
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Rising edges of source idx in the sampled waveform over the
  // counting window that follows acceptance at sample acc.
  function automatic int edges(int idx, int acc, int w);
    int c = 0;
    for (int j = acc + 1; j <= acc + w + 2; j++)
      if (j < HMAX && hist[j][idx] && !hist[j-1][idx]) c++;
    return c;
  endfunction

  task automatic run(input int a, input int b, input int w,
                     input bit use4, input bit poke, input string tag,
                     output int o_ca, output int o_cb, output int o_r,
                     output int o_t, output int o_e, output int o_s);
    int acc, n, weff, ea, eb, mx, u;
    bit seen, isq;
    u = use4 ? 1 : 0;
    mx = use4 ? 15 : 65535;
    weff = (w == 0) ? 1 : w;
    isq = (a == b);
    n = 0;
    while (!(use4 ? ready4 : ready) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " ready"}, int'(use4 ? ready4 : ready), 1);
    @(negedge clk);
    sel_a = 4'(a); sel_b = 4'(b); window = 16'(w);
    if (use4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    acc = cyc - 1;
    start = 1'b0; start4 = 1'b0;
    sel_a = 4'($urandom); sel_b = 4'($urandom);
    window = 16'($urandom);
    n = 0;
    seen = use4 ? rv4 : rv;
    while (!seen && n < weff + 20) begin
      if (poke && n == 3) begin
        if (use4) start4 = 1'b1; else start = 1'b1;
      end
      @(posedge clk); #1; n++;
      start = 1'b0; start4 = 1'b0;
      seen = use4 ? rv4 : rv;
    end
    chk({tag, " latency"}, n, isq ? 0 : weff + 5);
    if (isq) begin
      ea = last_a[u]; eb = last_b[u];
    end else begin
      ea = edges(a, acc, weff); if (ea > mx) ea = mx;
      eb = edges(b, acc, weff); if (eb > mx) eb = mx;
    end
    last_a[u] = ea; last_b[u] = eb;
    o_ca = use4 ? int'(ca4) : int'(ca);
    o_cb = use4 ? int'(cb4) : int'(cb);
    o_r = int'(use4 ? resp4 : resp);
    o_t = int'(use4 ? tie4 : tie);
    o_e = int'(use4 ? err4 : err);
    o_s = int'(use4 ? sat4 : sat);
    chk({tag, " cnt_a"}, o_ca, ea);
    chk({tag, " cnt_b"}, o_cb, eb);
    chk({tag, " resp"}, o_r, int'(!isq && ea > eb));
    chk({tag, " tie"}, o_t, int'(!isq && ea == eb));
    chk({tag, " err"}, o_e, int'(isq));
    chk({tag, " sat"}, o_s, int'(!isq && (ea == mx || eb == mx)));
    @(posedge clk); #1;
    chk({tag, " pulse"}, int'(use4 ? rv4 : rv), 0);
    chk({tag, " hold"}, use4 ? int'(ca4) : int'(ca), ea);
  endtask

  typedef struct {
    int a; int b; int w; bit use4;
    int lo_a; int hi_a; int lo_b; int hi_b;
    int r; int t; int e; int s;
  } vec_t;

  vec_t tv[6];
  int oa, ob, orr, ot, oe, os;
  int nv;

  initial begin
    for (int i = 0; i < 16; i++) begin
      per[i] = $urandom_range(3, 24);
      ph[i]  = $urandom_range(0, 23);
    end
    per[0] = 2;  ph[0] = 0;
    per[1] = 4;  ph[1] = 1;
    per[2] = 4;  ph[2] = 1;
    per[3] = 4;  ph[3] = 0;
    per[4] = 16; ph[4] = 3;
    per[5] = 8;  ph[5] = 0;
    per[7] = 6;  ph[7] = 0;
    last_a = '{0, 0}; last_b = '{0, 0};
    ext_osc = '0; rst = 1'b1; start = 1'b0; start4 = 1'b0;
    sel_a = '0; sel_b = '0; window = '0;

    tv[0] = '{3, 5, 64, 1'b0, 15, 17, 7, 9, 1, 0, 0, 0};
    tv[1] = '{5, 3, 64, 1'b0, 7, 9, 15, 17, 0, 0, 0, 0};
    tv[2] = '{1, 2, 40, 1'b0, 9, 11, 9, 11, 0, 1, 0, 0};
    tv[3] = '{7, 7, 64, 1'b0, 9, 11, 9, 11, 0, 0, 1, 0};
    tv[4] = '{0, 4, 100, 1'b1, 15, 15, 0, 14, 1, 0, 0, 1};
    tv[5] = '{3, 5, 0, 1'b0, 0, 2, 0, 1, -1, -1, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", int'(ready), 1);
    chk("rst valid", int'(rv), 0);
    chk("rst resp", int'({resp, tie, err, sat}), 0);
    chk("rst cnt_a", int'(ca), 0);
    chk("rst cnt_b", int'(cb), 0);
    chk("rst ready4", int'(ready4), 1);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run(tv[k].a, tv[k].b, tv[k].w, tv[k].use4, 1'b0,
          $sformatf("vec%0d", k), oa, ob, orr, ot, oe, os);
      chk_rng($sformatf("vec%0d spec_a", k), oa, tv[k].lo_a, tv[k].hi_a);
      chk_rng($sformatf("vec%0d spec_b", k), ob, tv[k].lo_b, tv[k].hi_b);
      if (tv[k].r >= 0) chk($sformatf("vec%0d spec_r", k), orr, tv[k].r);
      if (tv[k].t >= 0) chk($sformatf("vec%0d spec_t", k), ot, tv[k].t);
      chk($sformatf("vec%0d spec_e", k), oe, tv[k].e);
      chk($sformatf("vec%0d spec_s", k), os, tv[k].s);
    end

    @(negedge clk);
    sel_a = 4'd3; sel_b = 4'd5; window = 16'd64; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    sel_a = 4'd1; sel_b = 4'd2; window = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort busy", int'(ready), 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort ready", int'(ready), 1);
    chk("abort valid", int'(rv), 0);
    chk("abort resp", int'({resp, tie, err, sat}), 0);
    chk("abort cnt_a", int'(ca), 0);
    chk("abort cnt_b", int'(cb), 0);
    last_a = '{0, 0}; last_b = '{0, 0};
    nv = 0;
    repeat (90) begin
      @(posedge clk); #1;
      if (rv || !ready) nv++;
    end
    chk("abort quiet", nv, 0);

    for (int k = 0; k < 25; k++) begin
      int a, b, w;
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 5) == 0) ? a : $urandom_range(0, 15);
      w = $urandom_range(0, 120);
      run(a, b, w, 1'b0, (a != b) && ($urandom_range(0, 1) == 1),
          $sformatf("rnd%0d", k), oa, ob, orr, ot, oe, os);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
